// File: rtl/single_port_ram.sv
// single_port_ram: 32 x 8 synchronous single-port RAM with registered read data.
// One shared address. Write takes priority over read when both enables are high.
// A synchronous reset clears every word and the read register.
module single_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [DATA_WIDTH-1:0] data_out_d;

    // Next-state for storage and read register. A write suppresses the read,
    // and when no read happens data_out keeps its last value.
    always_comb begin
        mem_d      = mem_q;
        data_out_d = data_out_q;
        if (write_en) begin
            mem_d[addr] = data_in;
        end else if (read_en) begin
            data_out_d = mem_q[addr];
        end
    end

    // State update. Reset overrides any access presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q      <= '{default: '0};
            data_out_q <= '0;
        end else begin
            mem_q      <= mem_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_single_port_ram.sv
// Self-checking bench for single_port_ram: directed scenarios followed by a
// random phase, all checked against an array-based reference model.
module tb_single_port_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       write_en;
    logic       read_en;
    logic [4:0] addr;
    logic [7:0] data_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ref_mem [32];
    logic [7:0] ref_out;

    single_port_ram dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .write_en (write_en),
        .read_en  (read_en),
        .addr     (addr),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, check data_out just after the edge.
    task automatic step(input logic r, input logic we, input logic re,
                        input logic [4:0] a, input logic [7:0] d, input string tag);
        rst      = r;
        write_en = we;
        read_en  = re;
        addr     = a;
        data_in  = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
            ref_out = 8'h00;
        end else if (we) begin
            ref_mem[a] = d;
        end else if (re) begin
            ref_out = ref_mem[a];
        end
        #1;
        chk(tag, data_out, ref_out);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_v;
        rst = 1'b1; write_en = 1'b0; read_en = 1'b0; addr = '0; data_in = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'hxx;
        ref_out = 8'hxx;

        // reset state
        step(1, 0, 0, 5'd0, 8'h00, "reset");
        chk("reset_out", data_out, 8'h00);

        // reset clears a written word
        step(0, 1, 0, 5'd3, 8'hFF, "wr3");
        step(1, 0, 0, 5'd0, 8'h00, "reset2");
        chk("post_reset_out", data_out, 8'h00);
        step(0, 0, 1, 5'd3, 8'h00, "rd3_after_reset");
        chk("rd3_zero", data_out, 8'h00);

        // basic write/read at both address extremes
        step(0, 1, 0, 5'd0,  8'hA5, "wr0");
        step(0, 1, 0, 5'd31, 8'h5A, "wr31");
        step(0, 0, 1, 5'd0,  8'h00, "rd0");
        chk("rd0_val", data_out, 8'hA5);
        step(0, 0, 1, 5'd31, 8'h00, "rd31");
        chk("rd31_val", data_out, 8'h5A);

        // full sweep
        for (int a = 0; a < 32; a++) begin
            exp_v = 8'(a * 3);
            step(0, 1, 0, 5'(a), exp_v, "sweep_wr");
        end
        for (int a = 0; a < 32; a++) begin
            exp_v = 8'(a * 3);
            step(0, 0, 1, 5'(a), 8'h00, "sweep_rd");
            chk("sweep_val", data_out, exp_v);
        end

        // simultaneous enables: write wins, no read
        step(0, 1, 0, 5'd7, 8'h11, "wr7");
        step(0, 1, 0, 5'd8, 8'h22, "wr8");
        step(0, 0, 1, 5'd8, 8'h00, "rd8");
        chk("rd8_val", data_out, 8'h22);
        step(0, 1, 1, 5'd7, 8'h33, "both_en");
        chk("both_en_hold", data_out, 8'h22);
        step(0, 0, 1, 5'd7, 8'h00, "rd7");
        chk("rd7_val", data_out, 8'h33);

        // hold while idle with changing address
        step(0, 1, 0, 5'd4, 8'h44, "wr4");
        step(0, 0, 1, 5'd4, 8'h00, "rd4");
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 5'(k * 9 + 1), 8'(k + 8'hC0), "idle");
            chk("idle_hold", data_out, 8'h44);
        end

        // reset on the same edge as a write
        step(0, 1, 0, 5'd9, 8'h77, "wr9");
        step(1, 1, 0, 5'd9, 8'h99, "rst_wr9");
        step(0, 0, 1, 5'd9, 8'h00, "rd9");
        chk("rd9_zero", data_out, 8'h00);

        // random phase: every word is known after the reset above
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
                 5'($urandom), 8'($urandom), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
